// File: rtl/if_df_buffer_pkg.sv
// Shared widths and bubble constants for the fetch/decode pipeline buffers.
package if_df_buffer_pkg;
    localparam int DEF_PC_W   = 8;
    localparam int DEF_INST_W = 16;
    localparam int DEF_NOP_W  = 4;
    localparam logic [DEF_INST_W-1:0] DEF_NOP_INST = '0;
endpackage

// File: rtl/if_df_buffer_if.sv
// Fetch-to-decode data bus: fetch-side inputs and registered decode-side outputs.
interface if_df_buffer_if
    import if_df_buffer_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int NOP_W  = DEF_NOP_W
);
    logic [PC_W-1:0]   pc_buff_in;
    logic [INST_W-1:0] inst_buff_in;
    logic [NOP_W-1:0]  nop_in;
    logic [PC_W-1:0]   pc_buff_out;
    logic [INST_W-1:0] inst_buff_out;
    logic [NOP_W-1:0]  nop_out;

    modport master (
        output pc_buff_in, inst_buff_in, nop_in,
        input  pc_buff_out, inst_buff_out, nop_out
    );

    modport slave (
        input  pc_buff_in, inst_buff_in, nop_in,
        output pc_buff_out, inst_buff_out, nop_out
    );
endinterface

// File: rtl/if_df_buffer_pipe_reg.sv
// pipe_reg: one pipeline field; flush loads the bubble value, en gates the load.
module pipe_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] val_d, val_q;

    // Flush outranks the enable so a stalled stage can still be squashed.
    always_comb begin
        val_d = val_q;
        if (flush)   val_d = RST_VAL;
        else if (en) val_d = d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) val_q <= RST_VAL;
        else      val_q <= val_d;
    end

    assign q = val_q;
endmodule

// File: rtl/if_df_buffer.sv
// IF/DF pipeline buffer: registers PC, instruction and nop tag between fetch and decode.
// Define IF_DF_STALL_EN to add the stall (hold) port.
module if_df_buffer
    import if_df_buffer_pkg::*;
#(
    parameter int                PC_W     = DEF_PC_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter int                NOP_W    = DEF_NOP_W,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
`ifdef IF_DF_STALL_EN
    input  logic                 stall,
`endif
    if_df_buffer_if.slave        bus
);
    logic load_en;

`ifdef IF_DF_STALL_EN
    assign load_en = ~stall;
`else
    assign load_en = 1'b1;
`endif

    pipe_reg #(.W(PC_W), .RST_VAL('0)) u_pc (
        .clk(clk), .rst(rst), .flush(flush), .en(load_en),
        .d(bus.pc_buff_in), .q(bus.pc_buff_out)
    );

    pipe_reg #(.W(INST_W), .RST_VAL(NOP_INST)) u_inst (
        .clk(clk), .rst(rst), .flush(flush), .en(load_en),
        .d(bus.inst_buff_in), .q(bus.inst_buff_out)
    );

    pipe_reg #(.W(NOP_W), .RST_VAL('0)) u_nop (
        .clk(clk), .rst(rst), .flush(flush), .en(load_en),
        .d(bus.nop_in), .q(bus.nop_out)
    );
endmodule

// File: tb/tb_if_df_buffer.sv
// Directed bench for if_df_buffer: reset, flush, pass-through and (with IF_DF_STALL_EN) stall.
module tb_if_df_buffer;
    localparam logic [15:0] NOP_I = 16'h0000;
    localparam logic [27:0] BUBBLE = {8'h00, NOP_I, 4'h0};

    logic clk = 1'b0;
    logic rst;
    logic flush;
`ifdef IF_DF_STALL_EN
    logic stall;
`endif
    int tests_run = 0;
    int fail_cnt  = 0;
    logic [27:0] got;

    if_df_buffer_if #(.PC_W(8), .INST_W(16), .NOP_W(4)) bus ();

    if_df_buffer #(.PC_W(8), .INST_W(16), .NOP_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
`ifdef IF_DF_STALL_EN
        .stall(stall),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] outs();
        return {bus.pc_buff_out, bus.inst_buff_out, bus.nop_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] pc, input logic [15:0] inst, input logic [3:0] nop);
        bus.pc_buff_in   = pc;
        bus.inst_buff_in = inst;
        bus.nop_in       = nop;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        drive(8'h77, 16'h7777, 4'h7);
        #1;
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL reset_initial got=%h exp=%h", got, BUBBLE); end
        tick();
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL reset_hold_edge got=%h exp=%h", got, BUBBLE); end
        rst = 1'b1;
        drive(8'h5A, 16'hC3C3, 4'h9);
        tick();
        got = outs(); tests_run++;
        if (got !== {8'h5A, 16'hC3C3, 4'h9}) begin fail_cnt++; $display("FAIL reset_release_load got=%h exp=%h", got, {8'h5A, 16'hC3C3, 4'h9}); end
        // Mid-cycle async assert: outputs must clear before the next edge.
        #2 rst = 1'b0;
        #1;
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL reset_async got=%h exp=%h", got, BUBBLE); end
        #1 rst = 1'b1;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(8'h34, 16'h4321, 4'h3);
        tick();
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL flush_edge1 got=%h exp=%h", got, BUBBLE); end
        drive(8'h34, 16'hFFFF, 4'hF);
        tick();
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL flush_edge2 got=%h exp=%h", got, BUBBLE); end
        drive(8'h34, 16'h1597, 4'h1);
        tick();
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL flush_edge3 got=%h exp=%h", got, BUBBLE); end
    endtask

    task automatic test_flush_release();
        flush = 1'b0;
        drive(8'hAA, 16'h1597, 4'h5);
        #1;
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL flush_release_pre_edge got=%h exp=%h", got, BUBBLE); end
        tick();
        got = outs(); tests_run++;
        if (got !== {8'hAA, 16'h1597, 4'h5}) begin fail_cnt++; $display("FAIL flush_release got=%h exp=%h", got, {8'hAA, 16'h1597, 4'h5}); end
    endtask

    task automatic test_pass_through();
        drive(8'h01, 16'h1111, 4'h1);
        #1;
        got = outs(); tests_run++;
        if (got !== {8'hAA, 16'h1597, 4'h5}) begin fail_cnt++; $display("FAIL pass_no_comb_path got=%h exp=%h", got, {8'hAA, 16'h1597, 4'h5}); end
        tick();
        got = outs(); tests_run++;
        if (got !== {8'h01, 16'h1111, 4'h1}) begin fail_cnt++; $display("FAIL pass_vec1 got=%h exp=%h", got, {8'h01, 16'h1111, 4'h1}); end
        drive(8'h02, 16'h2222, 4'h2);
        tick();
        got = outs(); tests_run++;
        if (got !== {8'h02, 16'h2222, 4'h2}) begin fail_cnt++; $display("FAIL pass_vec2 got=%h exp=%h", got, {8'h02, 16'h2222, 4'h2}); end
        drive(8'hFE, 16'h8001, 4'hA);
        tick();
        got = outs(); tests_run++;
        if (got !== {8'hFE, 16'h8001, 4'hA}) begin fail_cnt++; $display("FAIL pass_vec3 got=%h exp=%h", got, {8'hFE, 16'h8001, 4'hA}); end
    endtask

`ifdef IF_DF_STALL_EN
    task automatic test_stall();
        drive(8'h10, 16'hBEEF, 4'h3);
        tick();
        stall = 1'b1;
        drive(8'h20, 16'h0BAD, 4'h6);
        tick();
        got = outs(); tests_run++;
        if (got !== {8'h10, 16'hBEEF, 4'h3}) begin fail_cnt++; $display("FAIL stall_hold1 got=%h exp=%h", got, {8'h10, 16'hBEEF, 4'h3}); end
        drive(8'h30, 16'hCAFE, 4'h9);
        tick();
        got = outs(); tests_run++;
        if (got !== {8'h10, 16'hBEEF, 4'h3}) begin fail_cnt++; $display("FAIL stall_hold2 got=%h exp=%h", got, {8'h10, 16'hBEEF, 4'h3}); end
        flush = 1'b1;
        tick();
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL stall_flush_prio got=%h exp=%h", got, BUBBLE); end
        flush = 1'b0; stall = 1'b0;
        tick();
        got = outs(); tests_run++;
        if (got !== {8'h30, 16'hCAFE, 4'h9}) begin fail_cnt++; $display("FAIL stall_release got=%h exp=%h", got, {8'h30, 16'hCAFE, 4'h9}); end
    endtask
`endif

    task automatic test_reset_during_flush();
        drive(8'h55, 16'hAAAA, 4'h7);
        tick();
        flush = 1'b1;
        #2 rst = 1'b0;
        #1;
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL rst_in_flush_async got=%h exp=%h", got, BUBBLE); end
        flush = 1'b0;
        drive(8'h66, 16'hDDDD, 4'hC);
        tick();
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL rst_low_ignores_inputs got=%h exp=%h", got, BUBBLE); end
        rst = 1'b1;
        flush = 1'b1;
        tick();
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL rst_release_flush got=%h exp=%h", got, BUBBLE); end
        flush = 1'b0;
        tick();
        got = outs(); tests_run++;
        if (got !== {8'h66, 16'hDDDD, 4'hC}) begin fail_cnt++; $display("FAIL rst_resume_load got=%h exp=%h", got, {8'h66, 16'hDDDD, 4'hC}); end
`ifdef IF_DF_STALL_EN
        stall = 1'b1;
        #2 rst = 1'b0;
        #1;
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL rst_in_stall_async got=%h exp=%h", got, BUBBLE); end
        #1 rst = 1'b1;
        tick();
        got = outs(); tests_run++;
        if (got !== BUBBLE) begin fail_cnt++; $display("FAIL rst_release_stall_hold got=%h exp=%h", got, BUBBLE); end
        stall = 1'b0;
        tick();
        got = outs(); tests_run++;
        if (got !== {8'h66, 16'hDDDD, 4'hC}) begin fail_cnt++; $display("FAIL rst_stall_resume got=%h exp=%h", got, {8'h66, 16'hDDDD, 4'hC}); end
`endif
    endtask

    initial begin
`ifdef IF_DF_STALL_EN
        stall = 1'b0;
`endif
        test_reset();
        test_flush();
        test_flush_release();
        test_pass_through();
`ifdef IF_DF_STALL_EN
        test_stall();
`endif
        test_reset_during_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule
